// File: rtl/servo_track_mapper.sv
// Centroid-to-servo mapper: 3-stage fixed-point coordinate mapping, per-period
// slew limiting, pan/tilt PWM generation and a lost-target return-to-home timeout.
module servo_track_mapper #(
    parameter int WIDTH           = 1280,
    parameter int HEIGHT          = 720,
    parameter int MIN_X           = 125000,
    parameter int MAX_X           = 375000,
    parameter int MIN_Y           = 155000,
    parameter int MAX_Y           = 290000,
    parameter bit INVERT_X        = 1'b1,
    parameter bit INVERT_Y        = 1'b0,
    parameter int FRAC            = 8,
    parameter int PERIOD_CYCLES   = 2000000,
    parameter int MAX_STEP_X      = 10000,
    parameter int MAX_STEP_Y      = 10000,
    parameter int TIMEOUT_PERIODS = 25
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        valid_in,
    input  logic [10:0] x_in,
    input  logic [9:0]  y_in,
    output logic        pwm_x_out,
    output logic        pwm_y_out,
    output logic [20:0] cmd_x_out,
    output logic [20:0] cmd_y_out,
    output logic        period_start_out,
    output logic        lost_out
);
    localparam int PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_PERIODS + 1);

    localparam logic [20:0] HOME_X = 21'((MIN_X + MAX_X) / 2);
    localparam logic [20:0] HOME_Y = 21'((MIN_Y + MAX_Y) / 2);
    localparam logic [31:0] MULT_X = 32'((longint'(MAX_X - MIN_X) << FRAC) / longint'(WIDTH - 1));
    localparam logic [31:0] MULT_Y = 32'((longint'(MAX_Y - MIN_Y) << FRAC) / longint'(HEIGHT - 1));
    localparam logic [10:0] XLIM   = 11'(WIDTH - 1);
    localparam logic [10:0] YLIM   = 11'(HEIGHT - 1);
    localparam logic signed [21:0] STEP_X = 22'(MAX_STEP_X);
    localparam logic signed [21:0] STEP_Y = 22'(MAX_STEP_Y);
    localparam logic [PW-1:0] LAST_CNT  = PW'(PERIOD_CYCLES - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT_PERIODS - 1);

    typedef enum logic {TRACK, LOST} state_t;

    function automatic logic [10:0] fold(input logic [10:0] c, input logic [10:0] lim,
                                         input logic inv);
        logic [10:0] cl;
        cl = (c > lim) ? lim : c;
        return inv ? (lim - cl) : cl;
    endfunction

    function automatic logic [20:0] sat_cmd(input logic [31:0] off, input int lo, input int hi);
        logic [32:0] t;
        t = {1'b0, off} + 33'(lo);
        if (t < 33'(lo))
            return 21'(lo);
        if (t > 33'(hi))
            return 21'(hi);
        return t[20:0];
    endfunction

    function automatic logic [20:0] slew(input logic [20:0] tgt, input logic [20:0] cur,
                                         input logic signed [21:0] step);
        logic signed [21:0] diff;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (diff > step)
            return cur + step[20:0];
        if (diff < -step)
            return cur - step[20:0];
        return tgt;
    endfunction

    logic [10:0]   x_p0, y_p0;
    logic [31:0]   prod_x_p1, prod_y_p1;
    logic          vld_p0, vld_p1;
    logic [PW-1:0] period_cnt;
    logic [TW-1:0] timeout_cnt;
    logic [20:0]   target_x, target_y;
    state_t        state;
    logic          wrap, expire;

    assign wrap   = (period_cnt == LAST_CNT);
    assign expire = wrap && (state == TRACK) && (timeout_cnt == LAST_TICK);

    // S1: clamp + mirror, S2: fixed-point scale; data path carries no reset
    always_ff @(posedge clk_in) begin
        x_p0      <= fold(x_in, XLIM, INVERT_X);
        y_p0      <= fold({1'b0, y_in}, YLIM, INVERT_Y);
        prod_x_p1 <= 32'(x_p0) * MULT_X;
        prod_y_p1 <= 32'(y_p0) * MULT_Y;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            period_cnt       <= '0;
            period_start_out <= 1'b0;
            pwm_x_out        <= 1'b0;
            pwm_y_out        <= 1'b0;
            vld_p0           <= 1'b0;
            vld_p1           <= 1'b0;
            timeout_cnt      <= '0;
            state            <= LOST;
            lost_out         <= 1'b1;
            target_x         <= HOME_X;
            target_y         <= HOME_Y;
            cmd_x_out        <= HOME_X;
            cmd_y_out        <= HOME_Y;
        end else begin
            vld_p0 <= valid_in;
            vld_p1 <= vld_p0;

            period_cnt <= wrap ? '0 : period_cnt + PW'(1);
            // Outputs follow period_cnt by one cycle, so the pulse begins on the
            // period_start_out cycle and spans exactly cmd cycles.
            period_start_out <= (period_cnt == '0);
            pwm_x_out        <= (32'(period_cnt) < 32'(cmd_x_out));
            pwm_y_out        <= (32'(period_cnt) < 32'(cmd_y_out));

            // Slew reads the pre-update target, so an S3 write on the wrap waits a period
            if (wrap) begin
                cmd_x_out <= slew(target_x, cmd_x_out, STEP_X);
                cmd_y_out <= slew(target_y, cmd_y_out, STEP_Y);
            end

            // S3: saturate into the pulse range; a landing valid beats timeout expiry
            if (vld_p1) begin
                target_x    <= sat_cmd(prod_x_p1 >> FRAC, MIN_X, MAX_X);
                target_y    <= sat_cmd(prod_y_p1 >> FRAC, MIN_Y, MAX_Y);
                timeout_cnt <= '0;
                state       <= TRACK;
                lost_out    <= 1'b0;
            end else if (expire) begin
                target_x    <= HOME_X;
                target_y    <= HOME_Y;
                timeout_cnt <= '0;
                state       <= LOST;
                lost_out    <= 1'b1;
            end else if (wrap && state == TRACK) begin
                timeout_cnt <= timeout_cnt + TW'(1);
            end
        end
    end
endmodule

// File: tb/tb_servo_track_mapper.sv
// Scoreboard bench for servo_track_mapper: directed centroids push expected per-period
// cmd/lost records; a monitor checks them and the PWM widths at every period start.
`timescale 1ns/1ps
module tb_servo_track_mapper;
    localparam int P = 400;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [10:0] x_in;
    logic [9:0]  y_in;
    logic        pwm_x, pwm_y, period_start_out, lost_out;
    logic [20:0] cmd_x, cmd_y;

    typedef struct packed {
        logic [20:0] cx;
        logic [20:0] cy;
        logic        lost;
    } rec_t;

    rec_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Scaled-down pulse ranges: HOME=(250,222), MULT_X=50, MULT_Y=48
    servo_track_mapper #(
        .WIDTH(1280), .HEIGHT(720),
        .MIN_X(125), .MAX_X(375), .MIN_Y(155), .MAX_Y(290),
        .INVERT_X(1'b1), .INVERT_Y(1'b0), .FRAC(8),
        .PERIOD_CYCLES(P), .MAX_STEP_X(10), .MAX_STEP_Y(10), .TIMEOUT_PERIODS(3)
    ) dut (
        .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in), .x_in(x_in), .y_in(y_in),
        .pwm_x_out(pwm_x), .pwm_y_out(pwm_y), .cmd_x_out(cmd_x), .cmd_y_out(cmd_y),
        .period_start_out(period_start_out), .lost_out(lost_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    initial begin : monitor
        rec_t cur;
        rec_t prev;
        bit   have_prev;
        int   hx, hy, sidx;
        have_prev = 1'b0;
        hx = 0;
        hy = 0;
        sidx = 0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                have_prev = 1'b0;
                hx = 0;
                hy = 0;
            end else begin
                if (period_start_out) begin
                    sidx++;
                    if (have_prev) begin
                        check($sformatf("p%0d pwm_x width", sidx), hx, 32'(prev.cx));
                        check($sformatf("p%0d pwm_y width", sidx), hy, 32'(prev.cy));
                    end
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL p%0d scoreboard empty actual=period_start required=queued_record", sidx);
                        have_prev = 1'b0;
                    end else begin
                        cur = exp_q.pop_front();
                        check($sformatf("p%0d cmd_x", sidx), 32'(cmd_x), 32'(cur.cx));
                        check($sformatf("p%0d cmd_y", sidx), 32'(cmd_y), 32'(cur.cy));
                        check($sformatf("p%0d lost", sidx), 32'(lost_out), 32'(cur.lost));
                        prev = cur;
                        have_prev = 1'b1;
                    end
                    hx = 0;
                    hy = 0;
                end
                if (pwm_x) hx++;
                if (pwm_y) hy++;
            end
        end
    end

    task automatic wait_start();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start_out && n < P + 20);
        if (!period_start_out) begin
            checks++;
            failures++;
            $display("FAIL period_start wait actual=none_in_%0d_cycles required=pulse", n);
        end
    endtask

    task automatic push_exp(input int ex, input int ey, input bit el);
        rec_t r;
        r.cx = 21'(ex);
        r.cy = 21'(ey);
        r.lost = el;
        exp_q.push_back(r);
    endtask

    // Wait for a period start, optionally strobe one centroid 'off' cycles later,
    // then queue what the next period start must show.
    task automatic period_step(input bit dv, input int off, input logic [10:0] x,
                               input logic [9:0] y, input int ex, input int ey, input bit el);
        wait_start();
        repeat (off) @(negedge clk);
        if (dv) begin
            valid_in = 1'b1;
            x_in = x;
            y_in = y;
            @(negedge clk);
            valid_in = 1'b0;
        end
        push_exp(ex, ey, el);
    endtask

    int ramp_x[12] = '{270, 280, 290, 300, 310, 320, 330, 340, 350, 360, 370, 374};
    int ramp_y[12] = '{202, 192, 182, 172, 162, 155, 155, 155, 155, 155, 155, 155};
    int home_x[11] = '{344, 334, 324, 314, 304, 294, 284, 274, 264, 254, 250};
    int home_y[11] = '{185, 195, 205, 215, 222, 222, 222, 222, 222, 222, 222};
    bit home_l[11] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};

    initial begin : stimulus
        valid_in = 1'b0;
        x_in = '0;
        y_in = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset cmd_x", 32'(cmd_x), 250);
        check("reset cmd_y", 32'(cmd_y), 222);
        check("reset lost", 32'(lost_out), 1);
        check("reset pwm_x", 32'(pwm_x), 0);
        check("reset pwm_y", 32'(pwm_y), 0);
        check("reset period_start", 32'(period_start_out), 0);

        push_exp(250, 222, 1'b1);
        #2 rst_n = 1'b1;
        period_step(1'b0, 50, 0, 0, 250, 222, 1'b1);

        // First centroid (0,0): lost must fall exactly with the third-edge target write
        wait_start();
        repeat (50) @(negedge clk);
        valid_in = 1'b1;
        x_in = 11'd0;
        y_in = 10'd0;
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        check("lost before S3", 32'(lost_out), 1);
        @(negedge clk);
        check("lost at S3", 32'(lost_out), 0);
        push_exp(260, 212, 1'b0);

        for (int i = 0; i < 12; i++)
            period_step(1'b1, 50, 11'd0, 10'd0, ramp_x[i], ramp_y[i], 1'b0);

        period_step(1'b1, 50, 11'd1279, 10'd360, 364, 165, 1'b0);
        period_step(1'b1, 50, 11'd2047, 10'd1023, 354, 175, 1'b0);

        // Silence: expiry after the third wrap, then slew back home
        for (int i = 0; i < 11; i++)
            period_step(1'b0, 50, 11'd0, 10'd0, home_x[i], home_y[i], home_l[i]);

        // S3 write on the wrap edge: next period still uses the old target
        period_step(1'b1, P - 4, 11'd0, 10'd0, 250, 222, 1'b0);
        period_step(1'b0, 50, 11'd0, 10'd0, 260, 212, 1'b0);
        period_step(1'b0, 50, 11'd0, 10'd0, 270, 202, 1'b0);
        // S3 write on the expiry wrap: valid wins, slew still uses the old target
        period_step(1'b1, P - 4, 11'd1279, 10'd360, 280, 192, 1'b0);
        period_step(1'b0, 50, 11'd0, 10'd0, 270, 202, 1'b0);
        period_step(1'b0, 50, 11'd0, 10'd0, 260, 212, 1'b0);

        // Mid-pulse reset
        wait_start();
        repeat (50) @(negedge clk);
        check("pwm_x high before reset", 32'(pwm_x), 1);
        check("pwm_y high before reset", 32'(pwm_y), 1);
        #2 rst_n = 1'b0;
        #1;
        check("pwm_x async drop", 32'(pwm_x), 0);
        check("pwm_y async drop", 32'(pwm_y), 0);
        check("mid reset cmd_x", 32'(cmd_x), 250);
        check("mid reset cmd_y", 32'(cmd_y), 222);
        check("mid reset lost", 32'(lost_out), 1);
        push_exp(250, 222, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first period_start after release", 32'(period_start_out), 1);
        period_step(1'b0, 50, 11'd0, 10'd0, 250, 222, 1'b1);
        wait_start();
        repeat (5) @(negedge clk);
        check("scoreboard drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
